div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter N, default 32: operand/result width, matching the shared radix-4 SRT divider.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..16; IDW = $clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low (rst == 0 resets on the clock edge).
REQ-005 reqValid  input  NREQ  per-requester request valid.
REQ-006 reqReady  output  NREQ  per-requester accept; at most one bit set per cycle.
REQ-007 reqX  input  NREQ*N  dividends, requester i at bits [i*N +: N].
REQ-008 reqY  input  NREQ*N  divisors, same packing.
REQ-009 reqSigned  input  NREQ  per-requester signed-operation flag.
REQ-010 divRst  output  1  active-high synchronous reset to the divider.
REQ-011 divStart  output  1  divider start pulse.
REQ-012 divX, divY  output  N each  divider operands.
REQ-013 divSigned  output  1  divider signedInput.
REQ-014 divQ, divR  input  N each  divider quotient/remainder.
REQ-015 divDone, divDivByZero  input  1 each  divider done and divide-by-zero flags.
REQ-016 respValid  output  1  result available.
REQ-017 respReady  input  1  consumer accepts the result.
REQ-018 respId  output  IDW  index of the requester that owns the result.
REQ-019 respQ, respR  output  N each  latched quotient/remainder.
REQ-020 respDivByZero  output  1  latched divide-by-zero flag.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, LAUNCH, WAIT and RESP.
REQ-023 IDLE: if any reqValid is set, the block SHALL grant one requester by round-robin, starting at (lastGrant+1) mod NREQ.
REQ-024 In the grant cycle, reqReady[g] SHALL be 1 combinationally; the block latches reqX/reqY/reqSigned of g and g into opX/opY/opSigned/opId, updates lastGrant to g, and moves to CLEAR.
REQ-025 reqReady SHALL be all-zero in every state other than IDLE; a requester holds its request until it sees reqReady.
REQ-026 CLEAR: divRst SHALL be 1 for exactly one cycle, then the FSM moves to LAUNCH, because the divider remains in its DONE state until reset.
REQ-027 LAUNCH: divStart SHALL be 1 for exactly one cycle with divRst = 0, then the FSM moves to WAIT.
REQ-028 divX/divY/divSigned SHALL equal opX/opY/opSigned continuously from CLEAR through WAIT, because the divider samples them after start as well.
REQ-029 Outside CLEAR..WAIT, divX, divY and divSigned SHALL be 0.
REQ-030 WAIT: when divDone == 1, the block SHALL latch divQ/divR/divDivByZero into respQ/respR/respDivByZero, set respId = opId, and move to RESP in the same edge.
REQ-031 RESP: respValid SHALL be 1 with all resp* fields stable.
REQ-032 RESP: on respValid & respReady, the FSM SHALL return to IDLE, so the earliest next grant is the following cycle.
REQ-033 RESP: respReady low SHALL hold the state indefinitely, and no new grant is made.
REQ-034 Latency from the grant cycle to the first respValid SHALL be 3 cycles plus the divider's done latency (divDone seen in WAIT); a divide-by-zero completes on the divider's START cycle.
REQ-035 Simultaneous requests SHALL resolve strictly round-robin; a continuously requesting requester waits at most NREQ-1 other transactions.
REQ-036 reqValid dropped by a requester before its grant SHALL have no effect.
REQ-037 Arbitration SHALL be purely combinational on reqValid in IDLE only; requests arriving in other states are not observed.

Reset
REQ-038 While rst == 0: state = IDLE, lastGrant = NREQ-1 (requester 0 wins first), reqReady = 0, respValid = 0, respId = 0, respQ = 0, respR = 0, respDivByZero = 0, divStart = 0, divX = 0, divY = 0, divSigned = 0, busy = 0, and divRst = 1.
REQ-039 A reset asserted in any state SHALL abort the transaction in flight; no response is produced for it, and the divider is held in reset.
REQ-040 On the first cycle after reset deassertion, divRst SHALL be 0 and IDLE arbitration SHALL be active.

Verification
REQ-041 Req0 X=100, Y=7, unsigned, respReady = 1 -> one reqReady[0] pulse, divRst pulse then divStart pulse, respValid with respId = 0, respQ = 14, respR = 2, respDivByZero = 0.
REQ-042 Req2 X=55, Y=0 -> respValid with respId = 2, respDivByZero = 1; the next request still completes correctly, proving divRst recovery.
REQ-043 All four requests asserted from reset with distinct operands -> grants in order 0, 1, 2, 3; respId sequence 0, 1, 2, 3, each with the correct quotient.
REQ-044 respReady held low 10 cycles in RESP while req1 is pending -> respValid and data stable, reqReady = 0; req1 granted the cycle after the handshake.
REQ-045 rst driven low during WAIT -> next cycle respValid = 0, busy = 0, divRst = 1; after release, X=0xFFFFFFFF / Y=1 from req3 returns respQ = 0xFFFFFFFF, respR = 0.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one radix-4 SRT divider among NREQ requesters.
// Each transaction: grant, clear the divider, launch it, wait for done, hold the response.
module div_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   reqValid,
    output logic [NREQ-1:0]   reqReady,
    input  logic [NREQ*N-1:0] reqX,
    input  logic [NREQ*N-1:0] reqY,
    input  logic [NREQ-1:0]   reqSigned,
    output logic              divRst,
    output logic              divStart,
    output logic [N-1:0]      divX,
    output logic [N-1:0]      divY,
    output logic              divSigned,
    input  logic [N-1:0]      divQ,
    input  logic [N-1:0]      divR,
    input  logic              divDone,
    input  logic              divDivByZero,
    output logic              respValid,
    input  logic              respReady,
    output logic [IDW-1:0]    respId,
    output logic [N-1:0]      respQ,
    output logic [N-1:0]      respR,
    output logic              respDivByZero,
    output logic              busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_next_state;
    logic [IDW-1:0] r_last;
    logic [N-1:0]   r_op_x;
    logic [N-1:0]   r_op_y;
    logic           r_op_signed;
    logic [IDW-1:0] r_op_id;

    logic           w_grant_vld;
    logic [IDW-1:0] w_grant_id;
    logic [IDW-1:0] w_idx;
    logic [N-1:0]   w_x_arr [NREQ];
    logic [N-1:0]   w_y_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_x_arr[gi] = reqX[gi*N +: N];
        assign w_y_arr[gi] = reqY[gi*N +: N];
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = r_last;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((32'(r_last) + k) % NREQ);
            if (!w_grant_vld && reqValid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    // Next state and decoded outputs
    always_comb begin
        w_next_state = r_state;
        reqReady     = '0;
        divRst       = ~rst;
        divStart     = 1'b0;
        divX         = '0;
        divY         = '0;
        divSigned    = 1'b0;
        respValid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (rst && w_grant_vld) begin
                    reqReady     = NREQ'(1) << w_grant_id;
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                divRst       = 1'b1;
                divX         = r_op_x;
                divY         = r_op_y;
                divSigned    = r_op_signed;
                w_next_state = S_LAUNCH;
            end
            S_LAUNCH: begin
                divStart     = rst;
                divX         = r_op_x;
                divY         = r_op_y;
                divSigned    = r_op_signed;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                divX      = r_op_x;
                divY      = r_op_y;
                divSigned = r_op_signed;
                if (divDone) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                respValid = 1'b1;
                if (respReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_last        <= IDW'(NREQ - 1);
            r_op_x        <= '0;
            r_op_y        <= '0;
            r_op_signed   <= 1'b0;
            r_op_id       <= '0;
            respId        <= '0;
            respQ         <= '0;
            respR         <= '0;
            respDivByZero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_grant_vld) begin
                r_last      <= w_grant_id;
                r_op_x      <= w_x_arr[w_grant_id];
                r_op_y      <= w_y_arr[w_grant_id];
                r_op_signed <= reqSigned[w_grant_id];
                r_op_id     <= w_grant_id;
            end
            if (r_state == S_WAIT && divDone) begin
                respQ         <= divQ;
                respR         <= divR;
                respDivByZero <= divDivByZero;
                respId        <= r_op_id;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider stub and a result scoreboard.
module tb_div_arbiter;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ*N-1:0] reqX;
    logic [NREQ*N-1:0] reqY;
    logic [NREQ-1:0]   reqSigned;
    logic              divRst;
    logic              divStart;
    logic [N-1:0]      divX;
    logic [N-1:0]      divY;
    logic              divSigned;
    logic [N-1:0]      divQ;
    logic [N-1:0]      divR;
    logic              divDone;
    logic              divDivByZero;
    logic              respValid;
    logic              respReady;
    logic [IDW-1:0]    respId;
    logic [N-1:0]      respQ;
    logic [N-1:0]      respR;
    logic              respDivByZero;
    logic              busy;

    div_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqX(reqX), .reqY(reqY), .reqSigned(reqSigned),
        .divRst(divRst), .divStart(divStart),
        .divX(divX), .divY(divY), .divSigned(divSigned),
        .divQ(divQ), .divR(divR), .divDone(divDone), .divDivByZero(divDivByZero),
        .respValid(respValid), .respReady(respReady), .respId(respId),
        .respQ(respQ), .respR(respR), .respDivByZero(respDivByZero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [N-1:0]   x;
        logic [N-1:0]   y;
        logic           s;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           dbz;
    } sb_t;

    sb_t            sb[$];
    int             resp_ids[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    int             last_g   = NREQ - 1;
    int             phase    = 0;
    int             lat_cnt  = 0;
    int             lat_exp  = 0;
    logic           lat_active = 1'b0;
    logic [NREQ-1:0] drop_mask = '0;
    logic [IDW-1:0] last_id;
    logic [N-1:0]   last_q;
    logic [N-1:0]   last_r;
    logic           last_dbz;

    function automatic logic [2*N:0] ref_div(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic s);
        logic [N-1:0] q;
        logic [N-1:0] r;
        if (y == '0) return {1'b1, {N{1'b1}}, x};
        if (s) begin
            q = N'($signed(x) / $signed(y));
            r = N'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {1'b0, q, r};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Divider stub: holds done until reset; divide-by-zero finishes on the start edge
    int dcnt;
    always @(posedge clk) begin
        if (divRst) begin
            divDone      <= 1'b0;
            divDivByZero <= 1'b0;
            divQ         <= '0;
            divR         <= '0;
            dcnt         <= 0;
        end else if (divStart) begin
            if (divY == '0) begin
                divDone      <= 1'b1;
                divDivByZero <= 1'b1;
                divQ         <= '1;
                divR         <= divX;
            end else begin
                dcnt <= 3 + int'(divX[1:0]);
            end
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                divDone <= 1'b1;
                {divDivByZero, divQ, divR} <= ref_div(divX, divY, divSigned);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic monitor();
        int   g;
        sb_t  e;
        logic [2*N:0] res;
        if (rst) begin
            if (busy) check("ready_while_busy", 128'(reqReady), 128'(0));
            else      check("div_ops_idle", 128'({divX, divY, divSigned}), 128'(0));
            if (lat_active) lat_cnt++;
            if (reqReady != '0) begin
                g = rr_pick(reqValid, last_g);
                check("grant", 128'(reqReady), (g < 0) ? 128'(0) : (128'(1) << g));
                if (g >= 0) begin
                    last_g = g;
                    e.id   = IDW'(g);
                    e.x    = reqX[g*N +: N];
                    e.y    = reqY[g*N +: N];
                    e.s    = reqSigned[g];
                    res    = ref_div(e.x, e.y, e.s);
                    {e.dbz, e.q, e.r} = res;
                    sb.push_back(e);
                    drop_mask[g] = 1'b1;
                    phase      = 1;
                    lat_active = 1'b1;
                    lat_cnt    = 0;
                    lat_exp    = e.dbz ? 4 : 7 + int'(e.x[1:0]);
                end
            end else if (phase == 1) begin
                check("clear_pulse", 128'({divRst, divStart}), 128'(2'b10));
                phase = 2;
            end else if (phase == 2 && sb.size() != 0) begin
                e = sb[$];
                check("launch", 128'({divRst, divStart, divX, divY, divSigned}),
                      128'({2'b01, e.x, e.y, e.s}));
                phase = 3;
            end
            if (respValid && lat_active) begin
                check("latency", 128'(lat_cnt), 128'(lat_exp));
                lat_active = 1'b0;
            end
            if (respValid && respReady) begin
                check("resp_sb_nonempty", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_id", 128'(respId), 128'(e.id));
                    check("resp_q", 128'(respQ), 128'(e.q));
                    check("resp_r", 128'(respR), 128'(e.r));
                    check("resp_dbz", 128'(respDivByZero), 128'(e.dbz));
                end
                resp_ids.push_back(int'(respId));
                last_id  = respId;
                last_q   = respQ;
                last_r   = respR;
                last_dbz = respDivByZero;
                phase    = 0;
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        reqValid  = reqValid & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic tick();
        to_neg();
        to_pos();
    endtask

    task automatic issue(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic s);
        reqX[i*N +: N] = x;
        reqY[i*N +: N] = y;
        reqSigned[i]   = s;
        reqValid[i]    = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        logic done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            if (reqValid == '0 && sb.size() == 0 && !busy && phase == 0) done = 1'b1;
        end
        check(tag, 128'(done), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic [N-1:0] snap_q;
        logic [N-1:0] snap_r;
        logic [IDW-1:0] snap_id;

        rst       = 1'b0;
        reqValid  = '0;
        reqX      = '0;
        reqY      = '0;
        reqSigned = '0;
        respReady = 1'b1;

        // All four requesters assert during reset with distinct operands
        issue(0, 32'd1000, 32'd10, 1'b0);
        issue(1, 32'd999, 32'd3, 1'b0);
        issue(2, 32'd12345, 32'd100, 1'b0);
        issue(3, 32'hFFFF_FFCE, 32'd3, 1'b1);
        repeat (3) tick();
        to_neg();
        check("rst_ready", 128'(reqReady), 128'(0));
        check("rst_resp", 128'({respValid, respId, respQ, respR, respDivByZero}), 128'(0));
        check("rst_div", 128'({divRst, divStart, divX, divY, divSigned}), 128'({1'b1, 66'd0}));
        check("rst_busy", 128'(busy), 128'(0));
        to_pos();
        rst = 1'b1;
        to_neg();
        check("post_rst_divrst", 128'(divRst), 128'(0));
        check("post_rst_grant0", 128'(reqReady), 128'(4'b0001));
        to_pos();
        drain("drain_rr4", 200);
        check("rr_count", 128'(resp_ids.size()), 128'(4));
        for (int i = 0; i < 4 && i < resp_ids.size(); i++)
            check("rr_order", 128'(resp_ids[i]), 128'(i));

        // Basic unsigned divide
        issue(0, 32'd100, 32'd7, 1'b0);
        drain("drain_basic", 50);
        check("basic_id", 128'(last_id), 128'(0));
        check("basic_qr", 128'({last_q, last_r, last_dbz}), 128'({32'd14, 32'd2, 1'b0}));

        // Divide by zero, then recovery
        issue(2, 32'd55, 32'd0, 1'b0);
        drain("drain_dbz", 50);
        check("dbz_id", 128'(last_id), 128'(2));
        check("dbz_flag", 128'(last_dbz), 128'(1));
        issue(1, 32'd1000, 32'd33, 1'b0);
        drain("drain_recover", 50);
        check("recover_qr", 128'({last_id, last_q, last_r, last_dbz}),
              128'({2'd1, 32'd30, 32'd10, 1'b0}));
        issue(3, 32'hFFFF_FF9C, 32'd7, 1'b1);
        drain("drain_signed", 50);
        check("signed_qr", 128'({last_q, last_r}), 128'({32'hFFFF_FFF2, 32'hFFFF_FFFE}));

        // Back-pressure in RESP with req1 pending
        respReady = 1'b0;
        issue(0, 32'd77, 32'd5, 1'b0);
        n = 0;
        while (!respValid && n < 50) begin
            tick();
            n++;
        end
        check("bp_reach_resp", 128'(respValid), 128'(1));
        issue(1, 32'd9, 32'd2, 1'b0);
        snap_q  = respQ;
        snap_r  = respR;
        snap_id = respId;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            check("bp_hold", 128'({respValid, busy, reqReady, respId, respQ, respR}),
                  128'({2'b11, 4'b0000, snap_id, snap_q, snap_r}));
            to_pos();
        end
        respReady = 1'b1;
        to_neg();
        to_pos();
        to_neg();
        check("bp_next_grant", 128'(reqReady), 128'(4'b0010));
        to_pos();
        drain("drain_bp", 50);
        check("bp_last", 128'({last_id, last_q, last_r}), 128'({2'd1, 32'd4, 32'd1}));

        // Reset during WAIT aborts the transaction
        issue(2, 32'd1000, 32'd3, 1'b0);
        n = 0;
        while (phase != 3 && n < 20) begin
            tick();
            n++;
        end
        check("abort_reach_wait", 128'(phase), 128'(3));
        rst = 1'b0;
        to_neg();
        to_pos();
        to_neg();
        check("abort_state", 128'({respValid, busy, divRst, divStart}), 128'(4'b0010));
        sb.delete();
        phase      = 0;
        lat_active = 1'b0;
        last_g     = NREQ - 1;
        to_pos();
        rst = 1'b1;
        issue(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        drain("drain_after_abort", 50);
        check("after_abort", 128'({last_id, last_q, last_r, last_dbz}),
              128'({2'd3, 32'hFFFF_FFFF, 32'd0, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
